// File: rtl/uart_pkg.sv
// Shared UART definitions for the receive and transmit sides of the link.
package uart_pkg;

   localparam int unsigned UART_DATA_W     = 8;
   // start + 8 data + stop
   localparam int unsigned UART_FRAME_BITS = 10;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } uart_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous input pin; resets to a chosen level.
module uart_rx_sync #(
   parameter logic ResetVal = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   logic [1:0] sync_q;

   // shift the pin through two flops to settle metastability
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= {2{ResetVal}};
      end else begin
         sync_q <= {sync_q[0], d_i};
      end
   end

   assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: centre-samples each bit and holds the byte until read.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 434
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   rx_in,
   input  logic                   ren,
   output logic [UART_DATA_W-1:0] dout,
   output logic                   valid,
   output logic                   frame_err,
   output logic                   overrun
);

   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
   // counter value on the cycle that samples the start bit / any later bit
   localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

   logic rx_s;

   uart_rx_sync #(
      .ResetVal(1'b1)
   ) u_sync (
      .clk(clk),
      .rst(rst),
      .d_i(rx_in),
      .q_o(rx_s)
   );

   uart_state_e            state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [2:0]             idx_q, idx_d;
   logic [UART_DATA_W-1:0] shreg_q, shreg_d;
   logic                   armed_q, armed_d;
   logic [UART_DATA_W-1:0] dout_q, dout_d;
   logic                   valid_q, valid_d;
   logic                   ovr_q, ovr_d;
   logic                   ferr_q, ferr_d;

   logic sample_tick, data_tick, good_stop, bad_stop;

   // state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (armed_q && !rx_s) state_d = START;
         START:   if (sample_tick) state_d = rx_s ? IDLE : DATA;
         DATA:    if (sample_tick && idx_q == 3'd7) state_d = STOP;
         STOP:    if (sample_tick) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // decode sample points and stop-bit outcome from the current state
   always_comb begin
      sample_tick = 1'b0;
      unique case (state_q)
         IDLE:        sample_tick = 1'b0;
         START:       sample_tick = (cnt_q == HALF_M1);
         DATA, STOP:  sample_tick = (cnt_q == FULL_M1);
         default:     sample_tick = 1'b0;
      endcase
      data_tick = (state_q == DATA) && sample_tick;
      good_stop = (state_q == STOP) && sample_tick && rx_s;
      bad_stop  = (state_q == STOP) && sample_tick && !rx_s;
   end

   // datapath next-state: counters, shift register, re-arm and output flags
   always_comb begin
      cnt_d   = (state_q == IDLE || sample_tick) ? '0 : cnt_q + 1'b1;
      idx_d   = idx_q;
      shreg_d = shreg_q;
      if (state_q != DATA) begin
         idx_d = 3'd0;
      end else if (data_tick) begin
         shreg_d[idx_q] = rx_s;
         if (idx_q != 3'd7) idx_d = idx_q + 3'd1;
      end

      // a failed stop bit blocks new starts until the line is seen high
      armed_d = armed_q;
      if (bad_stop) begin
         armed_d = 1'b0;
      end else if (rx_s) begin
         armed_d = 1'b1;
      end

      dout_d  = dout_q;
      valid_d = valid_q;
      ovr_d   = ovr_q;
      if (ren) begin
         valid_d = 1'b0;
         ovr_d   = 1'b0;
      end
      if (good_stop) begin
         dout_d  = shreg_q;
         valid_d = 1'b1;
         // a concurrent read consumed the old byte, so nothing was lost
         if (valid_q && !ren) ovr_d = 1'b1;
      end
      ferr_d = bad_stop;
   end

   // datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         idx_q   <= 3'd0;
         shreg_q <= '0;
         armed_q <= 1'b1;
         dout_q  <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shreg_q <= shreg_d;
         armed_q <= armed_d;
         dout_q  <= dout_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
         ferr_q  <= ferr_d;
      end
   end

   assign dout      = dout_q;
   assign valid     = valid_q;
   assign frame_err = ferr_q;
   assign overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are scored by a line-level sampling model.
module tb_uart_rx;

   localparam int unsigned CPB  = 16;
   localparam int          HALF = CPB / 2;
   // pin edge to valid: 2 sync + 1 detect + stop-bit centre offset
   localparam int          LAT  = 3 + HALF + 9 * CPB;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx_in;
   logic       ren;
   logic [7:0] dout;
   logic       valid;
   logic       frame_err;
   logic       overrun;

   uart_rx #(
      .CLKS_PER_BIT(CPB)
   ) dut (
      .clk(clk),
      .rst(rst),
      .rx_in(rx_in),
      .ren(ren),
      .dout(dout),
      .valid(valid),
      .frame_err(frame_err),
      .overrun(overrun)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit         err;
      logic [7:0] dout;
      bit         valid;
      bit         ovr;
      int         start;
      bit         chk_lat;
   } exp_t;

   exp_t       sb[$];
   exp_t       mon_e;
   int         n_checks = 0;
   int         n_pass   = 0;
   logic [7:0] m_dout;
   bit         m_valid;
   bit         m_ovr;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // line level x cycles after the start edge of a frame sent with period p
   function automatic bit line_at(input logic [7:0] b, input bit stop, input int p,
                                  input int x);
      int seg;
      seg = x / p;
      if (seg == 0) return 1'b0;
      else if (seg <= 8) return b[seg-1];
      else if (seg == 9) return stop;
      else return 1'b1;
   endfunction

   // what a receiver sampling at CPB-spaced bit centres sees: {stop, data}
   function automatic logic [8:0] sampled(input logic [7:0] b, input bit stop, input int p);
      logic [8:0] r;
      for (int i = 0; i < 8; i++) r[i] = line_at(b, stop, p, HALF + (i + 1) * CPB);
      r[8] = line_at(b, stop, p, HALF + 9 * CPB);
      return r;
   endfunction

   // called #1 after a posedge; returns #1 after a posedge
   task automatic send_frame(input logic [7:0] b, input bit stop, input int p, input int idle);
      logic [8:0] s;
      exp_t       e;
      s         = sampled(b, stop, p);
      e.start   = cyc;
      e.chk_lat = (p == CPB);
      if (s[8]) begin
         if (m_valid) m_ovr = 1'b1;
         m_valid = 1'b1;
         m_dout  = s[7:0];
         e.err   = 1'b0;
      end else begin
         e.err = 1'b1;
      end
      e.dout  = m_dout;
      e.valid = m_valid;
      e.ovr   = m_ovr;
      sb.push_back(e);
      for (int k = 0; k < 10; k++) begin
         rx_in = (k == 0) ? 1'b0 : (k == 9) ? stop : b[k-1];
         repeat (p) @(posedge clk);
         #1;
      end
      rx_in = 1'b1;
      repeat (idle) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_ren();
      ren = 1'b1;
      @(posedge clk);
      #1;
      ren     = 1'b0;
      m_valid = 1'b0;
      m_ovr   = 1'b0;
      chk("valid_after_ren", valid, 1'b0);
      chk("overrun_after_ren", overrun, 1'b0);
   endtask

   // monitor: score every new byte, overrun or frame error against the queue
   bit prev_v, prev_o, ferr_pend;
   always @(negedge clk) begin
      if (rst) begin
         prev_v    <= 1'b0;
         prev_o    <= 1'b0;
         ferr_pend <= 1'b0;
      end else begin
         if (ferr_pend) chk("frame_err_width", frame_err, 1'b0);
         ferr_pend <= 1'b0;
         if (frame_err || (valid && !prev_v) || (overrun && !prev_o)) begin
            if (sb.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_event: frame_err=%0b valid=%0b overrun=%0b, expected none",
                        frame_err, valid, overrun);
            end else begin
               mon_e = sb.pop_front();
               chk("event_kind", frame_err, mon_e.err);
               chk("dout", dout, mon_e.dout);
               chk("valid", valid, mon_e.valid);
               chk("overrun", overrun, mon_e.ovr);
               if (mon_e.chk_lat) chk("latency", cyc - mon_e.start, LAT);
               if (frame_err) ferr_pend <= 1'b1;
            end
         end
         prev_v <= valid;
         prev_o <= overrun;
      end
   end

   initial begin
      logic [7:0] b;
      int         p;
      bit         st;
      int         w;
      rst     = 1'b1;
      rx_in   = 1'b1;
      ren     = 1'b0;
      m_dout  = 8'h00;
      m_valid = 1'b0;
      m_ovr   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_dout", dout, 8'h00);
      chk("reset_valid", valid, 1'b0);
      chk("reset_frame_err", frame_err, 1'b0);
      chk("reset_overrun", overrun, 1'b0);
      rst = 1'b0;
      repeat (5) @(posedge clk);
      #1;

      // exact-baud byte, then read
      send_frame(8'hA5, 1'b1, CPB, 20);
      do_ren();

      // short low glitch on the idle line must be ignored
      rx_in = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rx_in = 1'b1;
      repeat (30) @(posedge clk);
      #1;
      send_frame(8'h3C, 1'b1, CPB, 20);
      do_ren();

      // broken stop bit
      send_frame(8'h81, 1'b0, CPB, 20);
      chk("ferr_valid_held", valid, m_valid);
      chk("ferr_dout_held", dout, m_dout);

      // back-to-back without a read: overrun
      send_frame(8'h11, 1'b1, CPB, 0);
      send_frame(8'h22, 1'b1, CPB, 20);
      chk("b2b_dout", dout, m_dout);
      chk("b2b_valid", valid, m_valid);
      chk("b2b_overrun", overrun, m_ovr);
      do_ren();

      // reset during bit 4 of 8'hFF, with a byte still pending
      send_frame(8'h5A, 1'b1, CPB, 20);
      rx_in = 1'b0;
      repeat (CPB) @(posedge clk);
      #1;
      rx_in = 1'b1;
      repeat (4 * CPB + HALF) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst     = 1'b0;
      m_dout  = 8'h00;
      m_valid = 1'b0;
      m_ovr   = 1'b0;
      chk("midrst_dout", dout, 8'h00);
      chk("midrst_valid", valid, 1'b0);
      chk("midrst_overrun", overrun, 1'b0);
      chk("midrst_frame_err", frame_err, 1'b0);
      repeat (6 * CPB) @(posedge clk);
      #1;
      send_frame(8'h0F, 1'b1, CPB, 20);
      do_ren();

      // off-nominal bit periods
      send_frame(8'h55, 1'b1, 15, 20);
      do_ren();
      send_frame(8'hAA, 1'b1, 17, 20);
      do_ren();

      // random traffic; broken stop bits only at nominal baud
      for (int n = 0; n < 24; n++) begin
         b  = 8'($urandom);
         p  = int'($urandom_range(15, 17));
         st = (p != CPB) || ($urandom_range(0, 5) != 0);
         send_frame(b, st, p, int'($urandom_range(16, 40)));
         if ($urandom_range(0, 1) == 1 || m_ovr) do_ren();
      end

      w = 0;
      while (sb.size() != 0 && w < 400) begin
         @(posedge clk);
         w++;
      end
      #1;
      chk("scoreboard_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
